dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the core's data port (daddr/ddata_w/d_r/d_w -> ddata_r). Holds a
//  word-organised RAM; serves byte/half/word loads and stores with a ready handshake and a
//  configurable wait-state count. Flags out-of-range, misaligned and conflicting requests.
// PARAMETERS
//  ADDR_WIDTH   10       word-address bits; RAM depth = 2**ADDR_WIDTH 32-bit words
//  BASE_ADDR    32'h0    byte address of word 0; must be 4-byte aligned
//  WAIT_STATES  1        extra cycles between acceptance and response, 0..15
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-low reset
//  d_r          in   1   load request; held until d_ready
//  d_w          in   1   store request; held until d_ready
//  daddr        in   32  byte address
//  ddata_w      in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  d_size       in   2   00 byte, 01 half, 10 word, 11 illegal
//  d_unsigned   in   1   load zero-extends when 1, sign-extends when 0
//  ddata_r      out  32  load data, valid while d_ready=1 and d_err=0; else 0
//  d_ready      out  1   one-cycle pulse: request completed
//  d_err        out  1   qualifies d_ready: request rejected, no RAM change
// BEHAVIOUR
//  - Reset: state IDLE, wait counter 0, ddata_r=0, d_ready=0, d_err=0. RAM contents not reset.
//  - FSM (state_t): IDLE -> WAIT -> RESP -> IDLE.
//    IDLE: if d_r|d_w, latch addr/data/size/unsigned/kind, counter=WAIT_STATES; next WAIT
//          (or RESP directly if WAIT_STATES=0).
//    WAIT: counter decrements each cycle; at counter==1 next RESP.
//    RESP: d_ready=1 (registered, exactly one cycle); next IDLE. No request accepted in RESP.
//  - Latency: request seen in IDLE at edge k -> d_ready high in cycle k+1+WAIT_STATES.
//    Back-to-back: next acceptance earliest at first IDLE cycle after RESP (throughput one
//    access per WAIT_STATES+2 cycles).
//  - Requester holds d_r/d_w/daddr/ddata_w stable until d_ready; inputs after acceptance are
//    ignored (latched copy is used).
//  - Error checks on latched request, evaluated on entry to RESP; any -> d_err=1, ddata_r=0, no write:
//    d_r&d_w both 1; d_size=11; misaligned (half: a[0]!=0, word: a[1:0]!=0);
//    (a-BASE_ADDR) >= 4*2**ADDR_WIDTH or a<BASE_ADDR (unsigned 32-bit compare, no wrap).
//  - Store: committed on the edge entering RESP. Byte lane = a[1:0], half lane = a[1]; other
//    lanes of the word unchanged.
//  - Load: word read on the edge entering RESP; lane extracted and extended to 32 bits.
//  - Store followed by load to same word returns the new data (no stale read).
//  - Reset mid-operation (WAIT or RESP): FSM returns to IDLE, outputs to 0; a store still in
//    WAIT is dropped; a store already in RESP has committed.
//  - Request deasserted before d_ready: protocol violation; access still completes as latched.
// STRUCTURE
//  - Package dmem_pkg: state_t enum {IDLE, WAIT, RESP}; size constants SZ_BYTE/SZ_HALF/SZ_WORD/
//    SZ_ILL; function for misalignment check.
//  - Sub-module dmem_lane: combinational store merge (old word, data, size, a[1:0] -> new
//    word) and load extract (word, size, unsigned, a[1:0] -> 32-bit result).
//  - RAM as reg array inferred as single-port synchronous memory; FSM, counter, checks in top.
// TESTING
//  1. WAIT_STATES=1: store word 32'hDEADBEEF @0x10, then load word @0x10 -> d_ready 2 cycles
//     after acceptance each, ddata_r=32'hDEADBEEF, d_err=0.
//  2. Store byte 8'hA5 @0x13 over 32'h11223344 @0x10; load byte signed @0x13 -> 32'hFFFFFFA5;
//     unsigned -> 32'h000000A5; load word @0x10 -> 32'hA5223344.
//  3. Load half @0x11, word @0x12, d_size=11, d_r&d_w=1 -> each d_ready with d_err=1,
//     ddata_r=0; word @0x10 unchanged afterwards.
//  4. Address BASE_ADDR+4*2**ADDR_WIDTH and BASE_ADDR-4 -> d_err=1; last word in range -> OK.
//  5. Store 32'hCAFEF00D, assert reset during WAIT (WAIT_STATES=3) -> outputs 0, FSM IDLE,
//     later load returns previous content.
//  6. WAIT_STATES=0: continuous d_r held 3 requests -> d_ready every 2nd cycle, one pulse each.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types, access-size encodings and the alignment
//                helper for the data-memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Halves must sit on even bytes, words on 4-byte boundaries.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a_lo);
    case (size)
      SZ_HALF: return a_lo[0];
      SZ_WORD: return |a_lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_lane
//  Description : Byte-lane steering for the data memory: merges store data
//                into the old word and extracts/extends load data.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  a_lo,
  input  logic        is_unsigned,
  output logic [31:0] new_word,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store merge: only the addressed lane(s) take the right-justified store data.
  always_comb begin
    new_word = word;
    case (size)
      SZ_BYTE: new_word[{a_lo, 3'b000} +: 8]      = wdata[7:0];
      SZ_HALF: new_word[{a_lo[1], 4'b0000} +: 16] = wdata[15:0];
      SZ_WORD: new_word = wdata;
      default: new_word = word;
    endcase
  end

  // Load extract: pick the addressed lane and zero- or sign-extend it.
  always_comb begin
    byte_sel = word[{a_lo, 3'b000} +: 8];
    half_sel = word[{a_lo[1], 4'b0000} +: 16];
    ld_data  = word;
    case (size)
      SZ_BYTE: ld_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SZ_HALF: ld_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default: ld_data = word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Word-organised data RAM serving byte/half/word loads and
//                stores with a ready handshake, configurable wait states and
//                error flagging of illegal requests.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_r,
  input  logic        d_w,
  input  logic [31:0] daddr,
  input  logic [31:0] ddata_w,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  output logic [31:0] ddata_r,
  output logic        d_ready,
  output logic        d_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d, wdata_q, wdata_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d, rd_q, rd_d, wr_q, wr_d;
  logic [31:0]        ddata_r_q, ddata_r_d;
  logic               d_ready_q, d_ready_d, d_err_q, d_err_d;

  logic [31:0]        req_addr, req_wdata, offset, rd_word, new_word, ld_data;
  logic [1:0]         req_size;
  logic               req_uns, req_rd, req_wr, req_err, enter_resp, mem_we;
  logic [ADDR_WIDTH-1:0] idx;

  logic [31:0] mem [DEPTH];

  // Request in flight: live inputs while IDLE (zero-wait path goes straight to RESP), latched copy after.
  always_comb begin
    req_addr  = (state_q == IDLE) ? daddr      : addr_q;
    req_wdata = (state_q == IDLE) ? ddata_w    : wdata_q;
    req_size  = (state_q == IDLE) ? d_size     : size_q;
    req_uns   = (state_q == IDLE) ? d_unsigned : uns_q;
    req_rd    = (state_q == IDLE) ? d_r        : rd_q;
    req_wr    = (state_q == IDLE) ? d_w        : wr_q;
    offset    = req_addr - BASE_ADDR;
    idx       = offset[ADDR_WIDTH+1:2];
    req_err   = (req_rd & req_wr) | (req_size == SZ_ILL) |
                is_misaligned(req_size, req_addr[1:0]) |
                (req_addr < BASE_ADDR) | ({1'b0, offset} >= SPAN);
    rd_word   = mem[idx];
  end

  dmem_lane u_lane (
    .word        (rd_word),
    .wdata       (req_wdata),
    .size        (req_size),
    .a_lo        (req_addr[1:0]),
    .is_unsigned (req_uns),
    .new_word    (new_word),
    .ld_data     (ld_data)
  );

  // Next state, wait counter, request latch and the registered response.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    uns_d     = uns_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    ddata_r_d = 32'h0;
    d_ready_d = 1'b0;
    d_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_r | d_w) begin
          addr_d  = daddr;
          wdata_d = ddata_w;
          size_d  = d_size;
          uns_d   = d_unsigned;
          rd_d    = d_r;
          wr_d    = d_w;
          cnt_d   = WS;
          state_d = (WS == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    enter_resp = (state_d == RESP) && (state_q != RESP);
    if (enter_resp) begin
      d_ready_d = 1'b1;
      d_err_d   = req_err;
      ddata_r_d = (req_rd & ~req_err) ? ld_data : 32'h0;
    end
    // Held off during reset so a request seen while in reset never writes.
    mem_we = enter_resp & req_wr & ~req_err & reset;
  end

  // Control and response registers; RAM contents are deliberately not reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      size_q    <= SZ_BYTE;
      uns_q     <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      ddata_r_q <= 32'h0;
      d_ready_q <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      ddata_r_q <= ddata_r_d;
      d_ready_q <= d_ready_d;
      d_err_q   <= d_err_d;
    end
  end

  // Store commit on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= new_word;
  end

  assign ddata_r = ddata_r_q;
  assign d_ready = d_ready_q;
  assign d_err   = d_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Directed self-checking bench for dmem_responder using three
//                instances: WS=1/base 0, WS=3/base 0x100, WS=0/base 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
  import dmem_pkg::*;

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] xd;
    logic        xe;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        d_r [3];
  logic        d_w [3];
  logic [31:0] daddr [3];
  logic [31:0] ddata_w [3];
  logic [1:0]  d_size [3];
  logic        d_unsigned [3];
  logic [31:0] ddata_r [3];
  logic        d_ready [3];
  logic        d_err [3];

  int          tests = 0;
  int          fails = 0;
  int          lat;
  logic [31:0] rd;
  logic        er;

  dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset(reset), .d_r(d_r[0]), .d_w(d_w[0]), .daddr(daddr[0]),
    .ddata_w(ddata_w[0]), .d_size(d_size[0]), .d_unsigned(d_unsigned[0]),
    .ddata_r(ddata_r[0]), .d_ready(d_ready[0]), .d_err(d_err[0]));

  dmem_responder #(.ADDR_WIDTH(4), .BASE_ADDR(32'h100), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset), .d_r(d_r[1]), .d_w(d_w[1]), .daddr(daddr[1]),
    .ddata_w(ddata_w[1]), .d_size(d_size[1]), .d_unsigned(d_unsigned[1]),
    .ddata_r(ddata_r[1]), .d_ready(d_ready[1]), .d_err(d_err[1]));

  dmem_responder #(.ADDR_WIDTH(4), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .d_r(d_r[2]), .d_w(d_w[2]), .daddr(daddr[2]),
    .ddata_w(ddata_w[2]), .d_size(d_size[2]), .d_unsigned(d_unsigned[2]),
    .ddata_r(ddata_r[2]), .d_ready(d_ready[2]), .d_err(d_err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One request on instance di: drive at a negedge, hold until d_ready seen, then release.
  // lat counts negedges after the drive point; -1 means no response within the bound.
  task automatic access(input int di, input vec_t v);
    @(negedge clk);
    d_r[di] = v.r; d_w[di] = v.w; daddr[di] = v.a; ddata_w[di] = v.wd;
    d_size[di] = v.sz; d_unsigned[di] = v.un;
    lat = -1; rd = 32'hx; er = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (d_ready[di] === 1'b1) begin
        lat = i; rd = ddata_r[di]; er = d_err[di];
        break;
      end
    end
    d_r[di] = 1'b0; d_w[di] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int di = 0; di < 3; di++) begin
      tests++;
      if (ddata_r[di] !== 32'h0 || d_ready[di] !== 1'b0 || d_err[di] !== 1'b0) begin
        fails++;
        $display("FAIL reset[%0d]: got data=%h rdy=%b err=%b, want 0/0/0",
                 di, ddata_r[di], d_ready[di], d_err[di]);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_word();
    vec_t v [2];
    v[0] = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, SZ_WORD, 1'b0, 32'h0,        1'b0};
    v[1] = '{1'b1, 1'b0, 32'h10, 32'h0,        SZ_WORD, 1'b0, 32'hDEADBEEF, 1'b0};
    foreach (v[i]) begin
      access(0, v[i]);
      tests++;
      if (lat != 2 || rd !== v[i].xd || er !== v[i].xe) begin
        fails++;
        $display("FAIL word[%0d]: got lat=%0d data=%h err=%b, want lat=2 data=%h err=%b",
                 i, lat, rd, er, v[i].xd, v[i].xe);
      end
    end
  endtask

  task automatic test_lanes();
    vec_t v [7];
    v[0] = '{1'b0, 1'b1, 32'h10, 32'h11223344, SZ_WORD, 1'b0, 32'h0,        1'b0};
    v[1] = '{1'b0, 1'b1, 32'h13, 32'h777777A5, SZ_BYTE, 1'b0, 32'h0,        1'b0};
    v[2] = '{1'b1, 1'b0, 32'h13, 32'h0,        SZ_BYTE, 1'b0, 32'hFFFFFFA5, 1'b0};
    v[3] = '{1'b1, 1'b0, 32'h13, 32'h0,        SZ_BYTE, 1'b1, 32'h000000A5, 1'b0};
    v[4] = '{1'b1, 1'b0, 32'h10, 32'h0,        SZ_WORD, 1'b0, 32'hA5223344, 1'b0};
    v[5] = '{1'b1, 1'b0, 32'h12, 32'h0,        SZ_HALF, 1'b0, 32'hFFFFA522, 1'b0};
    v[6] = '{1'b1, 1'b0, 32'h10, 32'h0,        SZ_HALF, 1'b1, 32'h00003344, 1'b0};
    foreach (v[i]) begin
      access(0, v[i]);
      tests++;
      if (lat != 2 || rd !== v[i].xd || er !== v[i].xe) begin
        fails++;
        $display("FAIL lanes[%0d]: got lat=%0d data=%h err=%b, want lat=2 data=%h err=%b",
                 i, lat, rd, er, v[i].xd, v[i].xe);
      end
    end
  endtask

  task automatic test_errors();
    vec_t v [5];
    v[0] = '{1'b1, 1'b0, 32'h11, 32'h0,        SZ_HALF, 1'b0, 32'h0,        1'b1};
    v[1] = '{1'b1, 1'b0, 32'h12, 32'h0,        SZ_WORD, 1'b0, 32'h0,        1'b1};
    v[2] = '{1'b0, 1'b1, 32'h10, 32'h99999999, SZ_ILL,  1'b0, 32'h0,        1'b1};
    v[3] = '{1'b1, 1'b1, 32'h10, 32'h88888888, SZ_WORD, 1'b0, 32'h0,        1'b1};
    v[4] = '{1'b1, 1'b0, 32'h10, 32'h0,        SZ_WORD, 1'b0, 32'hA5223344, 1'b0};
    foreach (v[i]) begin
      access(0, v[i]);
      tests++;
      if (lat != 2 || rd !== v[i].xd || er !== v[i].xe) begin
        fails++;
        $display("FAIL errors[%0d]: got lat=%0d data=%h err=%b, want lat=2 data=%h err=%b",
                 i, lat, rd, er, v[i].xd, v[i].xe);
      end
    end
  endtask

  task automatic test_range();
    vec_t v [8];
    int   di [8];
    int   xl [8];
    v[0] = '{1'b1, 1'b0, 32'h1000,     32'h0,        SZ_WORD, 1'b0, 32'h0,        1'b1};
    v[1] = '{1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        SZ_WORD, 1'b0, 32'h0,        1'b1};
    v[2] = '{1'b0, 1'b1, 32'hFFC,      32'h55AA55AA, SZ_WORD, 1'b0, 32'h0,        1'b0};
    v[3] = '{1'b1, 1'b0, 32'hFFC,      32'h0,        SZ_WORD, 1'b0, 32'h55AA55AA, 1'b0};
    v[4] = '{1'b1, 1'b0, 32'h140,      32'h0,        SZ_WORD, 1'b0, 32'h0,        1'b1};
    v[5] = '{1'b1, 1'b0, 32'hFC,       32'h0,        SZ_WORD, 1'b0, 32'h0,        1'b1};
    v[6] = '{1'b0, 1'b1, 32'h13C,      32'h0BADCAFE, SZ_WORD, 1'b0, 32'h0,        1'b0};
    v[7] = '{1'b1, 1'b0, 32'h13C,      32'h0,        SZ_WORD, 1'b0, 32'h0BADCAFE, 1'b0};
    for (int i = 0; i < 8; i++) begin
      di[i] = (i < 4) ? 0 : 1;
      xl[i] = (i < 4) ? 2 : 4;
    end
    foreach (v[i]) begin
      access(di[i], v[i]);
      tests++;
      if (lat != xl[i] || rd !== v[i].xd || er !== v[i].xe) begin
        fails++;
        $display("FAIL range[%0d]: got lat=%0d data=%h err=%b, want lat=%0d data=%h err=%b",
                 i, lat, rd, er, xl[i], v[i].xd, v[i].xe);
      end
    end
  endtask

  task automatic test_reset_mid();
    vec_t st;
    vec_t ld;
    logic seen;
    st = '{1'b0, 1'b1, 32'h120, 32'h01020304, SZ_WORD, 1'b0, 32'h0, 1'b0};
    ld = '{1'b1, 1'b0, 32'h120, 32'h0,        SZ_WORD, 1'b0, 32'h0, 1'b0};
    access(1, st);
    tests++;
    if (lat != 4 || er !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_pre: got lat=%0d err=%b, want lat=4 err=0", lat, er);
    end
    @(negedge clk);
    d_w[1] = 1'b1; daddr[1] = 32'h120; ddata_w[1] = 32'hCAFEF00D; d_size[1] = SZ_WORD;
    @(negedge clk);
    reset = 1'b0;
    d_w[1] = 1'b0;
    #1;
    tests++;
    if (ddata_r[1] !== 32'h0 || d_ready[1] !== 1'b0 || d_err[1] !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_out: got data=%h rdy=%b err=%b, want 0/0/0",
               ddata_r[1], d_ready[1], d_err[1]);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (d_ready[1] !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_noresp: got stray d_ready=%b, want 0", seen);
    end
    access(1, ld);
    tests++;
    if (lat != 4 || rd !== 32'h01020304 || er !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_load: got lat=%0d data=%h err=%b, want lat=4 data=01020304 err=0",
               lat, rd, er);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    vec_t        st;
    int          idx;
    logic        exp_rdy;
    words[0] = 32'hA0000001; words[1] = 32'hB0000002; words[2] = 32'hC0000003;
    for (int i = 0; i < 3; i++) begin
      st = '{1'b0, 1'b1, 32'(4 * i), words[i], SZ_WORD, 1'b0, 32'h0, 1'b0};
      access(2, st);
      tests++;
      if (lat != 1 || er !== 1'b0) begin
        fails++;
        $display("FAIL b2b_store[%0d]: got lat=%0d err=%b, want lat=1 err=0", i, lat, er);
      end
    end
    @(negedge clk);
    idx = 0;
    d_r[2] = 1'b1; d_w[2] = 1'b0; daddr[2] = 32'h0; d_size[2] = SZ_WORD; d_unsigned[2] = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      exp_rdy = (c % 2 == 0) && (c < 6);
      tests++;
      if (d_ready[2] !== exp_rdy) begin
        fails++;
        $display("FAIL b2b_ready[c%0d]: got %b, want %b", c, d_ready[2], exp_rdy);
      end
      if (d_ready[2] === 1'b1 && idx < 3) begin
        tests++;
        if (ddata_r[2] !== words[idx] || d_err[2] !== 1'b0) begin
          fails++;
          $display("FAIL b2b_data[%0d]: got data=%h err=%b, want data=%h err=0",
                   idx, ddata_r[2], d_err[2], words[idx]);
        end
        idx++;
        daddr[2] = 32'(4 * idx);
        if (idx == 3) d_r[2] = 1'b0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      d_r[i] = 1'b0; d_w[i] = 1'b0; daddr[i] = 32'h0; ddata_w[i] = 32'h0;
      d_size[i] = SZ_WORD; d_unsigned[i] = 1'b0;
    end
    test_reset();
    test_word();
    test_lanes();
    test_errors();
    test_range();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
